// File: rtl/sid_write_arbiter.sv
// Round-robin arbiter sharing the synth register-write port between the CPU bus decoder
// and the MCU SPI bridge; each write holds a fixed-width strobe followed by a recovery gap.
module sid_write_arbiter #(
    parameter int ADDR_WIDTH = 5,
    parameter int DATA_WIDTH = 8,
    parameter int WR_CYCLES  = 16,
    parameter int GAP_CYCLES = 2
) (
    input  logic                  clk16_i,
    input  logic                  reset_n_i,
    input  logic                  cpu_req_i,
    input  logic [ADDR_WIDTH-1:0] cpu_addr_i,
    input  logic [DATA_WIDTH-1:0] cpu_data_i,
    output logic                  cpu_ack_o,
    input  logic                  mcu_req_i,
    input  logic [ADDR_WIDTH-1:0] mcu_addr_i,
    input  logic [DATA_WIDTH-1:0] mcu_data_i,
    output logic                  mcu_ack_o,
    output logic                  sid_we_o,
    output logic [ADDR_WIDTH-1:0] sid_addr_o,
    output logic [DATA_WIDTH-1:0] sid_data_o,
    output logic                  busy_o
);
    // state | meaning
    // IDLE  | sampling requests each edge, strobe low
    // WRITE | sid_we_o high for WR_CYCLES cycles
    // GAP   | sid_we_o low for GAP_CYCLES recovery cycles
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WRITE = 2'd1,
        GAP   = 2'd2
    } state_t;

    localparam int MAX_CNT = (WR_CYCLES > GAP_CYCLES) ? WR_CYCLES : GAP_CYCLES;
    localparam int CNT_W   = $clog2(MAX_CNT + 1);
    localparam logic [CNT_W-1:0] WR_LOAD  = CNT_W'(WR_CYCLES - 1);
    localparam logic [CNT_W-1:0] GAP_LOAD = CNT_W'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);

    state_t                state_q;
    logic [CNT_W-1:0]      cnt_q;
    logic                  last_mcu_q;
    logic                  we_q;
    logic                  busy_q;
    logic                  cpu_ack_q;
    logic                  mcu_ack_q;
    logic [ADDR_WIDTH-1:0] addr_q;
    logic [DATA_WIDTH-1:0] data_q;
    logic                  grant_cpu_d;
    logic                  grant_mcu_d;

    // On a tie the requester that did not win last time gets the port.
    always_comb begin
        grant_cpu_d = cpu_req_i && (!mcu_req_i || last_mcu_q);
        grant_mcu_d = mcu_req_i && !grant_cpu_d;
    end

    always_ff @(posedge clk16_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            last_mcu_q <= 1'b1;
            we_q       <= 1'b0;
            busy_q     <= 1'b0;
            cpu_ack_q  <= 1'b0;
            mcu_ack_q  <= 1'b0;
            addr_q     <= '0;
            data_q     <= '0;
        end else begin
            cpu_ack_q <= 1'b0;
            mcu_ack_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (grant_cpu_d || grant_mcu_d) begin
                        state_q    <= WRITE;
                        cnt_q      <= WR_LOAD;
                        we_q       <= 1'b1;
                        busy_q     <= 1'b1;
                        cpu_ack_q  <= grant_cpu_d;
                        mcu_ack_q  <= grant_mcu_d;
                        last_mcu_q <= grant_mcu_d;
                        addr_q     <= grant_cpu_d ? cpu_addr_i : mcu_addr_i;
                        data_q     <= grant_cpu_d ? cpu_data_i : mcu_data_i;
                    end
                end
                WRITE: begin
                    if (cnt_q != '0) begin
                        cnt_q <= cnt_q - CNT_W'(1);
                    end else begin
                        we_q <= 1'b0;
                        if (GAP_CYCLES > 0) begin
                            state_q <= GAP;
                            cnt_q   <= GAP_LOAD;
                        end else begin
                            state_q <= IDLE;
                            busy_q  <= 1'b0;
                        end
                    end
                end
                GAP: begin
                    if (cnt_q != '0) begin
                        cnt_q <= cnt_q - CNT_W'(1);
                    end else begin
                        state_q <= IDLE;
                        busy_q  <= 1'b0;
                    end
                end
                default: begin
                    state_q <= IDLE;
                    we_q    <= 1'b0;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign cpu_ack_o  = cpu_ack_q;
    assign mcu_ack_o  = mcu_ack_q;
    assign sid_we_o   = we_q;
    assign sid_addr_o = addr_q;
    assign sid_data_o = data_q;
    assign busy_o     = busy_q;

endmodule

// File: tb/tb_sid_write_arbiter.sv
// Bench for sid_write_arbiter: directed scenarios plus randomized traffic checked against
// a grant-time model (a write granted at edge g owns the port for edges g .. g+PER-1).
module tb_sid_write_arbiter;
    localparam int AW   = 5;
    localparam int DW   = 8;
    localparam int WR   = 16;
    localparam int GAP  = 2;
    localparam int PER  = 1 + WR + GAP;
    localparam int PER0 = 1 + WR;

    logic          clk16_i   = 1'b0;
    logic          reset_n_i = 1'b0;
    logic          cpu_req_i = 1'b0;
    logic [AW-1:0] cpu_addr_i = '0;
    logic [DW-1:0] cpu_data_i = '0;
    logic          mcu_req_i = 1'b0;
    logic [AW-1:0] mcu_addr_i = '0;
    logic [DW-1:0] mcu_data_i = '0;
    logic          cpu_ack_o, mcu_ack_o, sid_we_o, busy_o;
    logic [AW-1:0] sid_addr_o;
    logic [DW-1:0] sid_data_o;

    logic          g0_cpu_req = 1'b0;
    logic [AW-1:0] g0_cpu_addr = '0;
    logic [DW-1:0] g0_cpu_data = '0;
    logic          g0_mcu_req = 1'b0;
    logic [AW-1:0] g0_mcu_addr = '0;
    logic [DW-1:0] g0_mcu_data = '0;
    logic          g0_cpu_ack, g0_mcu_ack, g0_we, g0_busy;
    logic [AW-1:0] g0_addr;
    logic [DW-1:0] g0_data;

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;

    // reference model: edge of the most recent grant and who won it
    int            m_g        = -1000;
    logic          m_last_mcu = 1'b1;
    logic [AW-1:0] m_addr     = '0;
    logic [DW-1:0] m_data     = '0;

    sid_write_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .WR_CYCLES(WR), .GAP_CYCLES(GAP)) dut (
        .clk16_i(clk16_i), .reset_n_i(reset_n_i),
        .cpu_req_i(cpu_req_i), .cpu_addr_i(cpu_addr_i), .cpu_data_i(cpu_data_i), .cpu_ack_o(cpu_ack_o),
        .mcu_req_i(mcu_req_i), .mcu_addr_i(mcu_addr_i), .mcu_data_i(mcu_data_i), .mcu_ack_o(mcu_ack_o),
        .sid_we_o(sid_we_o), .sid_addr_o(sid_addr_o), .sid_data_o(sid_data_o), .busy_o(busy_o)
    );

    sid_write_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .WR_CYCLES(WR), .GAP_CYCLES(0)) dut0 (
        .clk16_i(clk16_i), .reset_n_i(reset_n_i),
        .cpu_req_i(g0_cpu_req), .cpu_addr_i(g0_cpu_addr), .cpu_data_i(g0_cpu_data), .cpu_ack_o(g0_cpu_ack),
        .mcu_req_i(g0_mcu_req), .mcu_addr_i(g0_mcu_addr), .mcu_data_i(g0_mcu_data), .mcu_ack_o(g0_mcu_ack),
        .sid_we_o(g0_we), .sid_addr_o(g0_addr), .sid_data_o(g0_data), .busy_o(g0_busy)
    );

    always #5 clk16_i = ~clk16_i;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Advance one edge, update the model from the inputs seen at that edge, settle 1 ns.
    task automatic tick();
        @(posedge clk16_i);
        cyc++;
        if (!reset_n_i) begin
            m_g        = -1000;
            m_last_mcu = 1'b1;
            m_addr     = '0;
            m_data     = '0;
        end else if (cyc - m_g >= PER) begin
            if (cpu_req_i && (!mcu_req_i || m_last_mcu)) begin
                m_g = cyc; m_last_mcu = 1'b0; m_addr = cpu_addr_i; m_data = cpu_data_i;
            end else if (mcu_req_i) begin
                m_g = cyc; m_last_mcu = 1'b1; m_addr = mcu_addr_i; m_data = mcu_data_i;
            end
        end
        #1;
    endtask

    task automatic reset_pulse();
        cpu_req_i = 1'b0; mcu_req_i = 1'b0; g0_cpu_req = 1'b0; g0_mcu_req = 1'b0;
        reset_n_i = 1'b0;
        tick();
        tick();
        reset_n_i = 1'b1;
    endtask

    task automatic test_reset();
        int n_act;
        reset_n_i = 1'b0;
        tick();
        tick();
        n_tests++;
        if ({cpu_ack_o, mcu_ack_o, sid_we_o, busy_o, sid_addr_o, sid_data_o} !== '0) begin
            n_fail++;
            $display("FAIL reset_outputs: got ack=%b%b we=%b busy=%b addr=%h data=%h, want all 0",
                     cpu_ack_o, mcu_ack_o, sid_we_o, busy_o, sid_addr_o, sid_data_o);
        end
        n_tests++;
        if ({g0_cpu_ack, g0_mcu_ack, g0_we, g0_busy, g0_addr, g0_data} !== '0) begin
            n_fail++;
            $display("FAIL reset_outputs_gap0: got we=%b busy=%b, want all 0", g0_we, g0_busy);
        end
        reset_n_i = 1'b1;
        n_act = 0;
        for (int i = 0; i < 8; i++) begin
            tick();
            if (busy_o || sid_we_o || cpu_ack_o || mcu_ack_o) n_act++;
        end
        n_tests++;
        if (n_act != 0) begin
            n_fail++;
            $display("FAIL reset_idle: got %0d active cycles, want 0", n_act);
        end
    endtask

    task automatic test_single_write();
        int n_ack, n_we, n_busy, first_ack, last_we, last_busy, bad_ad;
        reset_pulse();
        cpu_addr_i = 5'h18; cpu_data_i = 8'h0F; cpu_req_i = 1'b1;
        n_ack = 0; n_we = 0; n_busy = 0; first_ack = -1; last_we = -1; last_busy = -1; bad_ad = 0;
        for (int i = 1; i <= 40; i++) begin
            tick();
            if (cpu_ack_o) begin
                n_ack++;
                if (first_ack < 0) first_ack = i;
                cpu_req_i = 1'b0;
            end
            if (mcu_ack_o) n_ack++;
            if (sid_we_o) begin
                n_we++;
                last_we = i;
                if (sid_addr_o !== 5'h18 || sid_data_o !== 8'h0F) bad_ad++;
            end
            if (busy_o) begin
                n_busy++;
                last_busy = i;
            end
        end
        n_tests++;
        if (n_ack != 1) begin n_fail++; $display("FAIL single_ack_count: got %0d want 1", n_ack); end
        n_tests++;
        if (first_ack != 1) begin n_fail++; $display("FAIL single_latency: got cycle %0d want 1", first_ack); end
        n_tests++;
        if (n_we != WR || last_we != WR) begin
            n_fail++; $display("FAIL single_we_len: got %0d cycles ending %0d want %0d", n_we, last_we, WR);
        end
        n_tests++;
        if (n_busy != WR + GAP || last_busy != WR + GAP) begin
            n_fail++; $display("FAIL single_busy_len: got %0d ending %0d want %0d", n_busy, last_busy, WR + GAP);
        end
        n_tests++;
        if (bad_ad != 0) begin n_fail++; $display("FAIL single_addr_data: got %0d bad cycles want 0", bad_ad); end
        n_tests++;
        if (sid_addr_o !== 5'h18 || sid_data_o !== 8'h0F) begin
            n_fail++; $display("FAIL single_hold_idle: got %h/%h want 18/0f", sid_addr_o, sid_data_o);
        end
    endtask

    task automatic test_tie();
        int n;
        int t [4];
        logic who [4];
        logic [AW-1:0] ga [4];
        logic [AW-1:0] ea [4];
        int both;
        ea = '{5'h01, 5'h02, 5'h05, 5'h06};
        reset_pulse();
        cpu_addr_i = 5'h01; cpu_data_i = 8'h10; mcu_addr_i = 5'h02; mcu_data_i = 8'h20;
        cpu_req_i = 1'b1; mcu_req_i = 1'b1;
        n = 0; both = 0;
        for (int i = 0; i < 120 && n < 4; i++) begin
            tick();
            if (cpu_ack_o && mcu_ack_o) both++;
            if (cpu_ack_o || mcu_ack_o) begin
                who[n] = mcu_ack_o; t[n] = cyc; ga[n] = sid_addr_o;
                n++;
                if (cpu_ack_o) cpu_addr_i = cpu_addr_i + 5'd4;
                else           mcu_addr_i = mcu_addr_i + 5'd4;
            end
        end
        cpu_req_i = 1'b0; mcu_req_i = 1'b0;
        n_tests++;
        if (n != 4 || both != 0) begin n_fail++; $display("FAIL tie_ack_count: got %0d (double %0d) want 4", n, both); end
        for (int k = 0; k < n; k++) begin
            n_tests++;
            if (who[k] !== logic'(k % 2) || ga[k] !== ea[k]) begin
                n_fail++;
                $display("FAIL tie_order[%0d]: got mcu=%b addr=%h want mcu=%0d addr=%h", k, who[k], ga[k], k % 2, ea[k]);
            end
            if (k > 0) begin
                n_tests++;
                if (t[k] - t[k-1] != PER) begin
                    n_fail++; $display("FAIL tie_spacing[%0d]: got %0d want %0d", k, t[k] - t[k-1], PER);
                end
            end
        end
        for (int i = 0; i < PER; i++) tick();
    endtask

    task automatic test_mid_request();
        int n;
        int t [3];
        logic who [3];
        logic [AW-1:0] ga [3];
        logic [DW-1:0] gd [3];
        logic [AW-1:0] ea [3];
        logic [DW-1:0] ed [3];
        ea = '{5'h03, 5'h1D, 5'h03};
        ed = '{8'h11, 8'hC3, 8'h11};
        reset_pulse();
        cpu_addr_i = 5'h03; cpu_data_i = 8'h11; cpu_req_i = 1'b1;
        n = 0;
        for (int i = 0; i < 100 && n < 3; i++) begin
            tick();
            if (cpu_ack_o || mcu_ack_o) begin
                who[n] = mcu_ack_o; t[n] = cyc; ga[n] = sid_addr_o; gd[n] = sid_data_o;
                n++;
                if (mcu_ack_o) mcu_req_i = 1'b0;
            end
            if (n >= 1 && cyc == t[0] + 5) begin
                mcu_addr_i = 5'h1D; mcu_data_i = 8'hC3; mcu_req_i = 1'b1;
            end
        end
        cpu_req_i = 1'b0; mcu_req_i = 1'b0;
        n_tests++;
        if (n != 3) begin n_fail++; $display("FAIL mid_ack_count: got %0d want 3", n); end
        for (int k = 0; k < n; k++) begin
            n_tests++;
            if (who[k] !== logic'(k == 1) || ga[k] !== ea[k] || gd[k] !== ed[k]) begin
                n_fail++;
                $display("FAIL mid_order[%0d]: got mcu=%b %h/%h want mcu=%0d %h/%h",
                         k, who[k], ga[k], gd[k], (k == 1) ? 1 : 0, ea[k], ed[k]);
            end
            if (k > 0) begin
                n_tests++;
                if (t[k] - t[k-1] != PER) begin
                    n_fail++; $display("FAIL mid_spacing[%0d]: got %0d want %0d", k, t[k] - t[k-1], PER);
                end
            end
        end
        for (int i = 0; i < PER; i++) tick();
    endtask

    task automatic test_data_change();
        logic got;
        int n_ack, bad;
        reset_pulse();
        cpu_addr_i = 5'h18; cpu_data_i = 8'h0F; cpu_req_i = 1'b1;
        got = 1'b0;
        for (int i = 0; i < 5 && !got; i++) begin
            tick();
            if (cpu_ack_o) got = 1'b1;
        end
        n_tests++;
        if (!got) begin
            n_fail++; $display("FAIL datachg_first_ack: got none want ack within 5 cycles");
        end else begin
            n_ack = 1;
            bad = (sid_data_o !== 8'h0F) ? 1 : 0;
            for (int j = 2; j <= WR + GAP; j++) begin
                tick();
                if (j == 3) cpu_data_i = 8'hAA;
                if (cpu_ack_o || mcu_ack_o) n_ack++;
                if (sid_data_o !== 8'h0F) bad++;
            end
            n_tests++;
            if (n_ack != 1) begin n_fail++; $display("FAIL datachg_acks: got %0d want 1", n_ack); end
            n_tests++;
            if (bad != 0) begin n_fail++; $display("FAIL datachg_hold: got %0d changed cycles want 0", bad); end
            tick();
            n_tests++;
            if (busy_o !== 1'b0 || cpu_ack_o !== 1'b0) begin
                n_fail++; $display("FAIL datachg_idle: got busy=%b ack=%b want 0/0", busy_o, cpu_ack_o);
            end
            tick();
            n_tests++;
            if (cpu_ack_o !== 1'b1 || sid_data_o !== 8'hAA) begin
                n_fail++; $display("FAIL datachg_next: got ack=%b data=%h want 1/aa", cpu_ack_o, sid_data_o);
            end
        end
        cpu_req_i = 1'b0;
        for (int i = 0; i < PER; i++) tick();
    endtask

    task automatic test_reset_mid_write();
        logic got, first_mcu;
        reset_pulse();
        cpu_addr_i = 5'h0A; cpu_data_i = 8'h55; cpu_req_i = 1'b1;
        got = 1'b0;
        for (int i = 0; i < 5 && !got; i++) begin
            tick();
            if (cpu_ack_o) got = 1'b1;
        end
        cpu_req_i = 1'b0;
        for (int i = 0; i < 4; i++) tick();
        n_tests++;
        if (sid_we_o !== 1'b1) begin n_fail++; $display("FAIL rstmid_pre_we: got %b want 1", sid_we_o); end
        #2;
        reset_n_i = 1'b0;
        #1;
        n_tests++;
        if ({sid_we_o, busy_o, sid_addr_o, sid_data_o} !== '0) begin
            n_fail++;
            $display("FAIL rstmid_async: got we=%b busy=%b addr=%h data=%h want 0", sid_we_o, busy_o, sid_addr_o, sid_data_o);
        end
        cpu_req_i = 1'b1; mcu_req_i = 1'b1; mcu_addr_i = 5'h11; mcu_data_i = 8'h99;
        tick();
        tick();
        #2;
        reset_n_i = 1'b1;
        got = 1'b0; first_mcu = 1'b0;
        for (int i = 0; i < 5 && !got; i++) begin
            tick();
            if (cpu_ack_o || mcu_ack_o) begin got = 1'b1; first_mcu = mcu_ack_o; end
        end
        cpu_req_i = 1'b0; mcu_req_i = 1'b0;
        n_tests++;
        if (!got || first_mcu !== 1'b0 || sid_addr_o !== 5'h0A) begin
            n_fail++;
            $display("FAIL rstmid_first_grant: got ack=%b mcu=%b addr=%h want cpu with addr 0a", got, first_mcu, sid_addr_o);
        end
        for (int i = 0; i < PER; i++) tick();
    endtask

    task automatic test_gap0();
        int n, n_we, n_idle;
        int t [5];
        logic who [5];
        logic got, first_mcu;
        reset_pulse();
        g0_cpu_addr = 5'h07; g0_cpu_data = 8'h70; g0_mcu_addr = 5'h0B; g0_mcu_data = 8'hB0;
        g0_cpu_req = 1'b1; g0_mcu_req = 1'b1;
        n = 0; n_we = 0; n_idle = 0;
        for (int i = 0; i < 150 && n < 5; i++) begin
            tick();
            if (g0_cpu_ack || g0_mcu_ack) begin
                who[n] = g0_mcu_ack; t[n] = cyc;
                n++;
            end
            if (n == 1) begin
                if (g0_we)    n_we++;
                if (!g0_busy) n_idle++;
            end
        end
        n_tests++;
        if (n != 5) begin n_fail++; $display("FAIL gap0_ack_count: got %0d want 5", n); end
        for (int k = 0; k < n; k++) begin
            n_tests++;
            if (who[k] !== logic'(k % 2)) begin
                n_fail++; $display("FAIL gap0_order[%0d]: got mcu=%b want %0d", k, who[k], k % 2);
            end
            if (k > 0) begin
                n_tests++;
                if (t[k] - t[k-1] != PER0) begin
                    n_fail++; $display("FAIL gap0_spacing[%0d]: got %0d want %0d", k, t[k] - t[k-1], PER0);
                end
            end
        end
        n_tests++;
        if (n_we != WR || n_idle != 1) begin
            n_fail++; $display("FAIL gap0_we_len: got we=%0d idle=%0d want %0d/1", n_we, n_idle, WR);
        end
        for (int i = 0; i < 4; i++) tick();
        n_tests++;
        if (g0_we !== 1'b1) begin n_fail++; $display("FAIL gap0_pre_we: got %b want 1", g0_we); end
        #2;
        reset_n_i = 1'b0;
        #1;
        n_tests++;
        if (g0_we !== 1'b0 || g0_busy !== 1'b0) begin
            n_fail++; $display("FAIL gap0_rst_async: got we=%b busy=%b want 0/0", g0_we, g0_busy);
        end
        tick();
        tick();
        #2;
        reset_n_i = 1'b1;
        got = 1'b0; first_mcu = 1'b0;
        for (int i = 0; i < 5 && !got; i++) begin
            tick();
            if (g0_cpu_ack || g0_mcu_ack) begin got = 1'b1; first_mcu = g0_mcu_ack; end
        end
        n_tests++;
        if (!got || first_mcu !== 1'b0) begin
            n_fail++; $display("FAIL gap0_first_grant: got ack=%b mcu=%b want cpu", got, first_mcu);
        end
        g0_cpu_req = 1'b0; g0_mcu_req = 1'b0;
        for (int i = 0; i < PER; i++) tick();
    endtask

    task automatic test_random();
        int d, n_shown;
        logic e_we, e_busy, e_ackc, e_ackm;
        reset_pulse();
        n_shown = 0;
        for (int i = 0; i < 1500; i++) begin
            tick();
            d      = cyc - m_g;
            e_we   = (d < WR);
            e_busy = (d < WR + GAP);
            e_ackc = (d == 0) && !m_last_mcu;
            e_ackm = (d == 0) && m_last_mcu;
            n_tests++;
            if ({cpu_ack_o, mcu_ack_o} !== {e_ackc, e_ackm}) begin
                n_fail++;
                if (n_shown++ < 20) $display("FAIL rand_ack @%0d: got %b%b want %b%b", cyc, cpu_ack_o, mcu_ack_o, e_ackc, e_ackm);
            end
            n_tests++;
            if (sid_we_o !== e_we || busy_o !== e_busy) begin
                n_fail++;
                if (n_shown++ < 20) $display("FAIL rand_we_busy @%0d: got %b/%b want %b/%b", cyc, sid_we_o, busy_o, e_we, e_busy);
            end
            n_tests++;
            if (sid_addr_o !== m_addr || sid_data_o !== m_data) begin
                n_fail++;
                if (n_shown++ < 20) $display("FAIL rand_addr_data @%0d: got %h/%h want %h/%h", cyc, sid_addr_o, sid_data_o, m_addr, m_data);
            end
            if (cpu_req_i && cpu_ack_o) begin
                if ($urandom_range(1, 0) == 0) cpu_req_i = 1'b0;
                else begin cpu_addr_i = AW'($urandom); cpu_data_i = DW'($urandom); end
            end else if (!cpu_req_i) begin
                if ($urandom_range(2, 0) == 0) begin
                    cpu_req_i = 1'b1; cpu_addr_i = AW'($urandom); cpu_data_i = DW'($urandom);
                end
            end else if ($urandom_range(31, 0) == 0) begin
                cpu_req_i = 1'b0;
            end
            if (mcu_req_i && mcu_ack_o) begin
                if ($urandom_range(1, 0) == 0) mcu_req_i = 1'b0;
                else begin mcu_addr_i = AW'($urandom); mcu_data_i = DW'($urandom); end
            end else if (!mcu_req_i) begin
                if ($urandom_range(2, 0) == 0) begin
                    mcu_req_i = 1'b1; mcu_addr_i = AW'($urandom); mcu_data_i = DW'($urandom);
                end
            end else if ($urandom_range(31, 0) == 0) begin
                mcu_req_i = 1'b0;
            end
        end
        cpu_req_i = 1'b0; mcu_req_i = 1'b0;
    endtask

    initial begin
        test_reset();
        test_single_write();
        test_tie();
        test_mid_request();
        test_data_change();
        test_reset_mid_write();
        test_gap0();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
